// File: rtl/thread_result_collector.sv
// Collects per-thread results through a round-robin arbiter into a show-ahead FIFO.
// The FIFO head is presented downstream, tagged with the index of the producing thread.
module thread_result_collector #(
    parameter int N_THREADS  = 16,
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int IDX_W      = $clog2(N_THREADS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_THREADS-1:0]          thr_valid,
    input  logic [N_THREADS*DATA_W-1:0]   thr_data,
    output logic [N_THREADS-1:0]          thr_ready,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic [IDX_W-1:0]              out_idx,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = IDX_W + DATA_W;

    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  grant;
    logic [IDX_W-1:0]  rr_next;
    logic              grant_vld;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              accept;
    logic              pop;
    logic [DATA_W-1:0] data_arr [N_THREADS];
    logic [ENT_W-1:0]  mem [FIFO_DEPTH];

    always_comb begin
        for (int i = 0; i < N_THREADS; i++) begin
            data_arr[i] = thr_data[i*DATA_W +: DATA_W];
        end
    end

    assign full = (count == CNT_W'(FIFO_DEPTH));

    // Search starts at rr_ptr and wraps; first valid thread wins.
    always_comb begin
        int               j;
        logic [IDX_W-1:0] jj;
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < N_THREADS; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N_THREADS) begin
                j = j - N_THREADS;
            end
            jj = IDX_W'(j);
            if (!grant_vld && thr_valid[jj]) begin
                grant     = jj;
                grant_vld = 1'b1;
            end
        end
    end

    // Gating with rst_n keeps thr_ready low while reset is held even if threads are valid.
    assign accept = grant_vld && !full && rst_n;

    always_comb begin
        thr_ready = '0;
        if (accept) begin
            thr_ready[grant] = 1'b1;
        end
    end

    assign rr_next = (grant == IDX_W'(N_THREADS - 1)) ? '0 : grant + IDX_W'(1);

    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready;
    assign fifo_count = count;
    assign {out_idx, out_data} = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                rr_ptr <= rr_next;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (accept && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !accept) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage is deliberately not reset; stale entries are hidden by count.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {grant, data_arr[grant]};
        end
    end

endmodule

// File: tb/tb_thread_result_collector.sv
// Directed bench for thread_result_collector: a reference model of arbitration and
// occupancy, with a scoreboard queue of accepted results compared at each pop.
module tb_thread_result_collector;

    localparam int N     = 16;
    localparam int DW    = 24;
    localparam int DEPTH = 8;
    localparam int IW    = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    thr_valid = '0;
    logic [N*DW-1:0] thr_data;
    logic [N-1:0]    thr_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_idx;
    logic            out_ready = 1'b0;
    logic [3:0]      fifo_count;

    logic [DW-1:0]   data_v [N];
    logic [N-1:0]    oneshot = '0;

    int              checks = 0;
    int              errors = 0;
    int              m_count = 0;
    int              m_rr = 0;
    logic [IW+DW-1:0] sb [$];
    int              log_idx [$];
    logic [N-1:0]    obs_rdy;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            thr_data[i*DW +: DW] = data_v[i];
        end
    end

    thread_result_collector #(
        .N_THREADS(N),
        .DATA_W(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .thr_valid(thr_valid),
        .thr_data(thr_data),
        .thr_ready(thr_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_idx(out_idx),
        .out_ready(out_ready),
        .fifo_count(fifo_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered 1 time unit after a rising edge with inputs already driven for this cycle.
    task automatic cycle();
        int               g;
        logic [IW-1:0]    j;
        logic [N-1:0]     exp_rdy;
        logic             popped;
        logic [IW+DW-1:0] ent;
        #3;
        g = -1;
        if (m_count < DEPTH) begin
            for (int k = 0; k < N; k++) begin
                j = IW'((m_rr + k) % N);
                if (g < 0 && thr_valid[j]) g = int'(j);
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[IW'(g)] = 1'b1;
        obs_rdy = thr_ready;
        check("thr_ready", thr_ready, exp_rdy);
        check("out_valid", out_valid, m_count != 0);
        check("fifo_count", fifo_count, m_count);
        popped = (m_count != 0) && out_ready;
        if (popped) begin
            ent = sb.pop_front();
            log_idx.push_back(int'(out_idx));
            check("out_idx", out_idx, ent[IW+DW-1:DW]);
            check("out_data", out_data, ent[DW-1:0]);
        end
        @(posedge clk);
        #1;
        if (g >= 0) begin
            sb.push_back({IW'(g), data_v[IW'(g)]});
            m_rr = (g + 1) % N;
            if (oneshot[IW'(g)]) thr_valid[IW'(g)] = 1'b0;
        end
        m_count += ((g >= 0) ? 1 : 0) - (popped ? 1 : 0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        thr_valid = '0;
        out_ready = 1'b0;
        oneshot   = '0;
        #2;
        rst_n = 1'b1;
        m_count = 0;
        m_rr    = 0;
        sb.delete();
        log_idx.delete();
    endtask

    initial begin
        for (int i = 0; i < N; i++) data_v[i] = DW'(i);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Asynchronous reset mid-stream with five entries buffered
        out_ready = 1'b0;
        thr_valid = '1;
        repeat (5) cycle();
        check("pre_reset_count", fifo_count, 5);
        rst_n = 1'b0;
        #1;
        check("rst_thr_ready", thr_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_fifo_count", fifo_count, 0);
        thr_valid = '0;
        #1;
        rst_n = 1'b1;
        m_count = 0;
        m_rr    = 0;
        sb.delete();
        log_idx.delete();
        repeat (3) cycle();

        // Single thread, one-cycle latency
        data_v[3] = 24'h00ABCD;
        oneshot[3] = 1'b1;
        out_ready = 1'b1;
        thr_valid = 16'h0008;
        cycle();
        check("single_rdy", obs_rdy, 16'h0008);
        cycle();
        check("single_pops", log_idx.size(), 1);
        if (log_idx.size() > 0) check("single_idx", log_idx[0], 3);
        cycle();
        check("single_cnt", fifo_count, 0);
        data_v[3] = DW'(3);

        // Round-robin fairness with every thread valid
        do_reset();
        out_ready = 1'b1;
        thr_valid = '1;
        repeat (20) cycle();
        check("rr_pops", log_idx.size(), 19);
        for (int k = 0; k < 17 && k < log_idx.size(); k++) check("rr_order", log_idx[k], k % 16);

        // Arbiter pointer wrap: rr_ptr = 15, threads 2 and 15 valid
        do_reset();
        out_ready = 1'b1;
        oneshot = '1;
        thr_valid = 16'h4000;
        cycle();
        thr_valid = 16'h8004;
        cycle();
        check("wrap_first", obs_rdy, 16'h8000);
        cycle();
        check("wrap_second", obs_rdy, 16'h0004);
        repeat (2) cycle();

        // Full FIFO and backpressure release
        do_reset();
        out_ready = 1'b0;
        thr_valid = '1;
        repeat (8) cycle();
        cycle();
        check("full_rdy", obs_rdy, 0);
        check("full_cnt", fifo_count, 8);
        out_ready = 1'b1;
        cycle();
        check("full_pop_rdy", obs_rdy, 0);
        cycle();
        check("after_full_grant", obs_rdy, 16'h0100);
        repeat (10) cycle();
        check("full_pops", log_idx.size() >= 9, 1);
        for (int k = 0; k < 9 && k < log_idx.size(); k++) check("full_order", log_idx[k], k);

        // Simultaneous accept and pop at count 4
        do_reset();
        out_ready = 1'b0;
        oneshot = '1;
        thr_valid = 16'h000F;
        repeat (4) cycle();
        check("sim_pre_cnt", fifo_count, 4);
        data_v[9] = 24'h123456;
        thr_valid = 16'h0200;
        out_ready = 1'b1;
        cycle();
        check("sim_cnt", fifo_count, 4);
        check("sim_head", out_idx, 1);
        repeat (6) cycle();
        check("sim_drain_cnt", fifo_count, 0);
        check("sim_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
